muldiv_unit: RTL and testbench
==============================

MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand and result width (8..64, even).
REQ-002 SHALL have port clk  input  1  single clock, rising-edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port start_i  input  1  launch request, sampled in IDLE only.
REQ-005 SHALL have port op_i  input  2  operation: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
REQ-006 SHALL have port annul_i  input  1  abort the in-flight operation (flush).
REQ-007 SHALL have port src_a_i  input  WIDTH  multiplicand / dividend.
REQ-008 SHALL have port src_b_i  input  WIDTH  multiplier / divisor.
REQ-009 SHALL have port busy_o  output  1  high in MUL or DIV state.
REQ-010 SHALL have port stallreq_o  output  1  stall request to CTRL: (IDLE & start_i & ~annul_i) | busy_o.
REQ-011 SHALL have port done_o  output  1  one-cycle pulse: hi_o/lo_o updated this cycle.
REQ-012 SHALL have port hi_o  output  WIDTH  product high half / remainder.
REQ-013 SHALL have port lo_o  output  WIDTH  product low half / quotient.
REQ-014 SHALL have port div_by_zero_o  output  1  sticky flag for the last result, cleared at next accepted start.

Function
REQ-015 SHALL implement FSM states IDLE, MUL, DIV, DONE.
REQ-016 IDLE: start_i & ~annul_i latches operands and op; op MULT/MULTU -> MUL, DIV/DIVU with src_b_i!=0 -> DIV, with src_b_i==0 -> DONE.
REQ-017 Signed ops SHALL latch absolute values plus result signs; unsigned ops use raw operands.
REQ-018 MUL SHALL perform radix-2 shift-add, one bit per cycle, exactly WIDTH cycles, then DONE.
REQ-019 DIV SHALL perform restoring division, one quotient bit per cycle, exactly WIDTH cycles, then DONE.
REQ-020 Iteration counter SHALL be $clog2(WIDTH)+1 bits, loaded with WIDTH-1 and counting down to 0.
REQ-021 DONE: hi_o/lo_o SHALL be written with sign-corrected results, done_o=1, next state IDLE; a start_i in DONE SHALL be ignored.
REQ-022 Signed product SHALL be negated (2*WIDTH bits) when operand signs differ.
REQ-023 Signed quotient sign = sign(a) XOR sign(b); remainder sign = sign(a).
REQ-024 Most-negative / -1 SHALL give quotient = most-negative (wrap), remainder 0, no flag.
REQ-025 Divide by zero SHALL give lo_o = all ones, hi_o = src_a_i, div_by_zero_o=1, done_o one cycle after start.
REQ-026 Latency (iterative): start accepted in cycle 0 -> done_o in cycle WIDTH+1.
REQ-027 annul_i in MUL/DIV SHALL return to IDLE next cycle, no done_o, hi_o/lo_o/div_by_zero_o unchanged.
REQ-028 annul_i together with start_i in IDLE SHALL suppress the launch.
REQ-029 start_i while busy_o SHALL be ignored; operands are not re-latched.
REQ-030 hi_o/lo_o SHALL hold the last result between operations.

Reset
REQ-031 rst SHALL force state IDLE, counter 0, hi_o=0, lo_o=0, done_o=0, busy_o=0, stallreq_o=0, div_by_zero_o=0, at any time including mid-operation.
REQ-032 First start after reset release SHALL behave as in REQ-016.

Configuration
REQ-033 Macro MULDIV_FAST_MUL_EN: when defined, MULT/MULTU SHALL go IDLE -> DONE using a single-cycle WIDTH x WIDTH multiplier, done_o in cycle 1; division unchanged.
REQ-034 Without MULDIV_FAST_MUL_EN, REQ-018 applies and no combinational full-width multiplier SHALL be synthesised.

Structure
REQ-035 Package muldiv_pkg SHALL hold op encodings (OP_MULT, OP_MULTU, OP_DIV, OP_DIVU) and FSM state encoding; shared with ID/EX decode.
REQ-036 Sub-module muldiv_div_step SHALL implement one combinational restoring-division step (partial remainder, divisor -> next remainder, quotient bit).

Verification (WIDTH=32)
REQ-037 MULTU 0xFFFFFFFF x 0xFFFFFFFF -> hi_o=0xFFFFFFFE, lo_o=0x00000001, done_o in cycle 33 (cycle 1 with MULDIV_FAST_MUL_EN).
REQ-038 MULT -3 x 7 -> hi_o=0xFFFFFFFF, lo_o=0xFFFFFFEB; stallreq_o high cycles 0..32, low in cycle 33 (done_o cycle).
REQ-039 DIV -7 / 2 -> lo_o=0xFFFFFFFD, hi_o=0xFFFFFFFF; DIV 0x80000000 / 0xFFFFFFFF -> lo_o=0x80000000, hi_o=0.
REQ-040 DIVU 100 / 0 -> done_o cycle 1, lo_o=0xFFFFFFFF, hi_o=0x00000064, div_by_zero_o=1; next valid start clears flag.
REQ-041 DIVU 9/4 annulled in cycle 10 -> busy_o low cycle 11, no done_o, hi_o/lo_o keep prior values; repeat with rst in cycle 10 -> all outputs 0.
REQ-042 start_i held high throughout a DIVU -> exactly one operation, one done_o pulse, new launch only from IDLE after DONE.

Source files
------------

// File: rtl/muldiv_pkg.sv
// -----------------------------------------------------------------------------
// muldiv_pkg
// Shared definitions for the iterative multiply/divide unit and the ID/EX
// decode stage that issues to it: operation encodings, FSM state encoding and
// small decode helpers.
// -----------------------------------------------------------------------------
package muldiv_pkg;

    typedef enum logic [1:0] {
        OP_MULT  = 2'b00,
        OP_MULTU = 2'b01,
        OP_DIV   = 2'b10,
        OP_DIVU  = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        MUL  = 2'b01,
        DIV  = 2'b10,
        DONE = 2'b11
    } state_e;

    function automatic logic op_is_div(input op_e op);
        return (op == OP_DIV) || (op == OP_DIVU);
    endfunction

    function automatic logic op_is_signed(input op_e op);
        return (op == OP_MULT) || (op == OP_DIV);
    endfunction

endpackage

// File: rtl/muldiv_div_step.sv
// -----------------------------------------------------------------------------
// muldiv_div_step
// One combinational restoring-division step. The partial remainder is shifted
// left with the next dividend bit; if the divisor fits, it is subtracted and
// the quotient bit is 1, otherwise the shifted value is kept.
//
// Ports
//   rem_in   : current partial remainder (always < divisor)
//   bit_in   : next dividend bit, MSB first
//   divisor  : divisor magnitude
//   rem_out  : next partial remainder
//   q_bit    : quotient bit produced by this step
// -----------------------------------------------------------------------------
module muldiv_div_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] rem_in,
    input  logic             bit_in,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] rem_out,
    output logic             q_bit
);

    logic [WIDTH:0] partial;
    logic [WIDTH:0] diff;

    assign partial = {rem_in, bit_in};
    assign diff    = partial - {1'b0, divisor};

    // rem_in < divisor keeps partial < 2*divisor, so diff fits in WIDTH bits
    // plus sign and its MSB is a reliable borrow indicator.
    assign q_bit   = ~diff[WIDTH];
    assign rem_out = q_bit ? diff[WIDTH-1:0] : partial[WIDTH-1:0];

endmodule

// File: rtl/muldiv_unit.sv
// -----------------------------------------------------------------------------
// muldiv_unit
// Iterative multiply / divide unit. MULT/MULTU use radix-2 shift-add (one bit
// per cycle), DIV/DIVU use restoring division (one quotient bit per cycle).
// Signed operations run on magnitudes and fix the result signs on completion.
// Results appear on hi_o/lo_o in the cycle done_o is high and are held until
// the next completed operation.
//
// Configuration
//   MULDIV_FAST_MUL_EN : when defined, MULT/MULTU complete through a
//                        single-cycle WIDTH x WIDTH multiplier (IDLE -> DONE).
//
// Ports
//   clk, rst       : clock, asynchronous active-high reset
//   start_i        : launch request, sampled in IDLE only
//   op_i           : 00 MULT, 01 MULTU, 10 DIV, 11 DIVU
//   annul_i        : abort the in-flight operation
//   src_a_i/src_b_i: multiplicand/dividend, multiplier/divisor
//   busy_o         : iterating (MUL or DIV state)
//   stallreq_o     : stall request to the pipeline control
//   done_o         : one-cycle pulse, hi_o/lo_o carry a new result
//   hi_o, lo_o     : product high/low half, or remainder/quotient
//   div_by_zero_o  : last result came from a division by zero
// -----------------------------------------------------------------------------
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_i,
    input  logic [1:0]       op_i,
    input  logic             annul_i,
    input  logic [WIDTH-1:0] src_a_i,
    input  logic [WIDTH-1:0] src_b_i,
    output logic             busy_o,
    output logic             stallreq_o,
    output logic             done_o,
    output logic [WIDTH-1:0] hi_o,
    output logic [WIDTH-1:0] lo_o,
    output logic             div_by_zero_o
);

    localparam int               CNT_W    = $clog2(WIDTH) + 1;
    localparam int               DW       = 2 * WIDTH;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WIDTH - 1);

    state_e           state;
    state_e           state_next;
    op_e              op;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] opnd_b;      // multiplicand / divisor magnitude
    logic [DW-1:0]    work;        // {acc, multiplier} or {remainder, dividend/quotient}
    logic             neg_lo;      // negate product / quotient
    logic             neg_hi;      // negate remainder

    logic             is_div;
    logic             is_signed;
    logic             b_zero;
    logic             accept;
    logic             last_iter;
    logic [WIDTH-1:0] abs_a;
    logic [WIDTH-1:0] abs_b;

    logic [WIDTH:0]   mul_sum;
    logic [DW-1:0]    mul_next;
    logic [DW-1:0]    div_next;
    logic [WIDTH-1:0] div_rem;
    logic             div_q;
    logic [DW-1:0]    prod_fix;
    logic [WIDTH-1:0] quo_fix;
    logic [WIDTH-1:0] rem_fix;

    assign op        = op_e'(op_i);
    assign is_div    = op_is_div(op);
    assign is_signed = op_is_signed(op);
    assign b_zero    = (src_b_i == '0);
    assign accept    = (state == IDLE) && start_i && !annul_i;
    assign last_iter = (cnt == '0);

    assign abs_a = (is_signed && src_a_i[WIDTH-1]) ? -src_a_i : src_a_i;
    assign abs_b = (is_signed && src_b_i[WIDTH-1]) ? -src_b_i : src_b_i;

    // Shift-add: add multiplicand into the high half when the current
    // multiplier bit (work[0]) is set, then shift the whole pair right; the
    // carry enters from the top.
    assign mul_sum  = {1'b0, work[DW-1:WIDTH]} + (work[0] ? {1'b0, opnd_b} : '0);
    assign mul_next = {mul_sum, work[WIDTH-1:1]};

    muldiv_div_step #(
        .WIDTH (WIDTH)
    ) u_div_step (
        .rem_in  (work[DW-1:WIDTH]),
        .bit_in  (work[WIDTH-1]),
        .divisor (opnd_b),
        .rem_out (div_rem),
        .q_bit   (div_q)
    );

    // Dividend bits leave at the top of the low half, quotient bits enter at
    // the bottom; after WIDTH steps the low half is the quotient.
    assign div_next = {div_rem, work[WIDTH-2:0], div_q};

    assign prod_fix = neg_lo ? -mul_next : mul_next;
    assign quo_fix  = neg_lo ? -div_next[WIDTH-1:0] : div_next[WIDTH-1:0];
    assign rem_fix  = neg_hi ? -div_next[DW-1:WIDTH] : div_next[DW-1:WIDTH];

`ifdef MULDIV_FAST_MUL_EN
    logic [DW-1:0] fast_mag;
    logic [DW-1:0] fast_prod;

    assign fast_mag  = DW'(abs_a) * DW'(abs_b);
    assign fast_prod = (is_signed && (src_a_i[WIDTH-1] ^ src_b_i[WIDTH-1])) ? -fast_mag : fast_mag;
`endif

    // ---------------------------------------------------------------- state
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of process ordering.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        // NOTE: default assignment first keeps this block free of latches.
        state_next = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    if (!is_div) begin
`ifdef MULDIV_FAST_MUL_EN
                        state_next = DONE;
`else
                        state_next = MUL;
`endif
                    end else if (b_zero) begin
                        state_next = DONE;
                    end else begin
                        state_next = DIV;
                    end
                end
            end
            MUL, DIV: begin
                if (annul_i) begin
                    state_next = IDLE;
                end else if (last_iter) begin
                    state_next = DONE;
                end
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        busy_o     = (state == MUL) || (state == DIV);
        done_o     = (state == DONE);
        stallreq_o = !rst && (accept || (state == MUL) || (state == DIV));
    end

    // ------------------------------------------------------------- datapath
    // Results are written on the edge entering DONE so they are visible in
    // the same cycle as done_o.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt           <= '0;
            opnd_b        <= '0;
            work          <= '0;
            neg_lo        <= 1'b0;
            neg_hi        <= 1'b0;
            hi_o          <= '0;
            lo_o          <= '0;
            div_by_zero_o <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        cnt           <= CNT_LOAD;
                        opnd_b        <= abs_b;
                        work          <= {{WIDTH{1'b0}}, abs_a};
                        neg_lo        <= is_signed && (src_a_i[WIDTH-1] ^ src_b_i[WIDTH-1]);
                        neg_hi        <= is_signed && src_a_i[WIDTH-1];
                        div_by_zero_o <= is_div && b_zero;
                        if (is_div && b_zero) begin
                            hi_o <= src_a_i;
                            lo_o <= '1;
                        end
`ifdef MULDIV_FAST_MUL_EN
                        if (!is_div) begin
                            {hi_o, lo_o} <= fast_prod;
                        end
`endif
                    end
                end
                MUL, DIV: begin
                    if (!annul_i) begin
                        cnt  <= cnt - CNT_W'(1);
                        work <= (state == MUL) ? mul_next : div_next;
                        if (last_iter) begin
                            if (state == MUL) begin
                                {hi_o, lo_o} <= prod_fix;
                            end else begin
                                hi_o <= rem_fix;
                                lo_o <= quo_fix;
                            end
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// -----------------------------------------------------------------------------
// tb_muldiv_unit
// Self-checking bench for muldiv_unit (WIDTH=32). A behavioural model tracks
// each accepted operation as "result due N cycles after acceptance" and a
// compare process checks every DUT output against it on each falling edge.
// Directed cases pin the model and the DUT to hand-computed values, then a
// randomized phase exercises starts, annuls, resets and corner operands.
// -----------------------------------------------------------------------------
module tb_muldiv_unit;
    import muldiv_pkg::*;

    localparam int W = 32;
`ifdef MULDIV_FAST_MUL_EN
    localparam int MUL_LAT = 1;
`else
    localparam int MUL_LAT = W + 1;
`endif
    localparam int DIV_LAT = W + 1;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start_i = 1'b0;
    logic [1:0]    op_i = 2'b00;
    logic          annul_i = 1'b0;
    logic [W-1:0]  src_a_i = '0;
    logic [W-1:0]  src_b_i = '0;
    logic          busy_o;
    logic          stallreq_o;
    logic          done_o;
    logic [W-1:0]  hi_o;
    logic [W-1:0]  lo_o;
    logic          div_by_zero_o;

    int n_checks = 0;
    int n_errors = 0;

    muldiv_unit #(
        .WIDTH (W)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .start_i       (start_i),
        .op_i          (op_i),
        .annul_i       (annul_i),
        .src_a_i       (src_a_i),
        .src_b_i       (src_b_i),
        .busy_o        (busy_o),
        .stallreq_o    (stallreq_o),
        .done_o        (done_o),
        .hi_o          (hi_o),
        .lo_o          (lo_o),
        .div_by_zero_o (div_by_zero_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference results straight from the arithmetic definitions.
    function automatic void ref_op(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                                   output logic [W-1:0] hi, output logic [W-1:0] lo, output logic dz);
        longint     pa;
        longint     pb;
        logic [63:0] p;
        int         sa;
        int         sb;
        dz = 1'b0;
        hi = '0;
        lo = '0;
        case (op)
            2'b00: begin
                pa = longint'($signed(a));
                pb = longint'($signed(b));
                p  = pa * pb;
                hi = p[63:32];
                lo = p[31:0];
            end
            2'b01: begin
                p  = {32'b0, a} * {32'b0, b};
                hi = p[63:32];
                lo = p[31:0];
            end
            default: begin
                if (b == '0) begin
                    hi = a;
                    lo = '1;
                    dz = 1'b1;
                end else if (op == 2'b10 && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
                    lo = 32'h8000_0000;
                    hi = '0;
                end else if (op == 2'b10) begin
                    sa = a;
                    sb = b;
                    lo = sa / sb;
                    hi = sa % sb;
                end else begin
                    lo = a / b;
                    hi = a % b;
                end
            end
        endcase
    endfunction

    // ------------------------------------------------------------- model
    bit          m_pending = 1'b0;
    int          m_age = 0;
    int          m_lat = 0;
    logic [W-1:0] m_hi = '0;
    logic [W-1:0] m_lo = '0;
    logic        m_dz = 1'b0;
    logic [W-1:0] m_rhi = '0;
    logic [W-1:0] m_rlo = '0;
    logic        m_rdz = 1'b0;

    initial begin
        forever begin
            @(posedge clk or posedge rst);
            if (rst) begin
                m_pending = 1'b0;
                m_hi = '0;
                m_lo = '0;
                m_dz = 1'b0;
            end else begin
                if (m_pending && m_age >= 1 && m_age < m_lat && annul_i) begin
                    m_pending = 1'b0;
                end else if ((!m_pending || m_age > m_lat) && start_i && !annul_i) begin
                    ref_op(op_i, src_a_i, src_b_i, m_rhi, m_rlo, m_rdz);
                    m_pending = 1'b1;
                    m_age = 0;
                    m_dz = m_rdz;
                    if (m_rdz) m_lat = 1;
                    else if (op_i[1]) m_lat = DIV_LAT;
                    else m_lat = MUL_LAT;
                end
                if (m_pending) begin
                    m_age++;
                    if (m_age == m_lat) begin
                        m_hi = m_rhi;
                        m_lo = m_rlo;
                    end
                end
            end
        end
    end

    // ----------------------------------------------------------- compare
    initial begin
        bit e_busy;
        bit e_done;
        bit e_idle;
        bit e_stall;
        forever begin
            @(negedge clk);
            e_busy  = m_pending && m_age >= 1 && m_age < m_lat;
            e_done  = m_pending && m_age == m_lat;
            e_idle  = !m_pending || m_age > m_lat;
            e_stall = !rst && ((e_idle && start_i && !annul_i) || e_busy);
            check("cmp_busy", 64'(busy_o), 64'(e_busy));
            check("cmp_done", 64'(done_o), 64'(e_done));
            check("cmp_stall", 64'(stallreq_o), 64'(e_stall));
            check("cmp_hi", 64'(hi_o), 64'(m_hi));
            check("cmp_lo", 64'(lo_o), 64'(m_lo));
            check("cmp_dz", 64'(div_by_zero_o), 64'(m_dz));
        end
    end

    // ------------------------------------------------------------ helpers
    // Caller is just after a rising edge with the unit idle; returns just
    // after the next rising edge (cycle 1 of the operation).
    task automatic launch(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        op_i = op;
        src_a_i = a;
        src_b_i = b;
        start_i = 1'b1;
        @(negedge clk);
        check("stall_on_start", 64'(stallreq_o), 64'd1);
        @(posedge clk);
        #1;
        start_i = 1'b0;
    endtask

    // Returns the cycle index of done_o and the stall-high cycles before it;
    // leaves the caller just after the edge following the done cycle.
    task automatic wait_done(output int lat, output int stall_cnt);
        lat = 1;
        stall_cnt = 0;
        @(negedge clk);
        while (done_o !== 1'b1 && lat < 100) begin
            if (stallreq_o) stall_cnt++;
            @(negedge clk);
            lat++;
        end
        check("done_seen", 64'(done_o), 64'd1);
        check("stall_at_done", 64'(stallreq_o), 64'd0);
        @(posedge clk);
        #1;
    endtask

    function automatic logic [W-1:0] pick();
        case ($urandom % 8)
            0:       return '0;
            1:       return 32'd1;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'h8000_0000;
            4:       return 32'h7FFF_FFFF;
            5:       return W'($urandom % 16);
            default: return W'($urandom);
        endcase
    endfunction

    // ------------------------------------------------------------ stimulus
    initial begin
        int lat;
        int scnt;
        int ndone;
        int done_at;
        logic [W-1:0] rh;
        logic [W-1:0] rl;
        logic rdz;

        // Reset state.
        repeat (3) @(negedge clk);
        check("rst_hi", 64'(hi_o), 64'd0);
        check("rst_lo", 64'(lo_o), 64'd0);
        check("rst_busy", 64'(busy_o), 64'd0);
        check("rst_done", 64'(done_o), 64'd0);
        check("rst_stall", 64'(stallreq_o), 64'd0);
        check("rst_dz", 64'(div_by_zero_o), 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Pin the reference model with hand-computed values.
        ref_op(OP_DIV, 32'hFFFF_FFF9, 32'd2, rh, rl, rdz);
        check("ref_div_hi", 64'(rh), 64'hFFFF_FFFF);
        check("ref_div_lo", 64'(rl), 64'hFFFF_FFFD);
        ref_op(OP_MULT, 32'hFFFF_FFFD, 32'd7, rh, rl, rdz);
        check("ref_mult_lo", 64'(rl), 64'hFFFF_FFEB);
        ref_op(OP_DIVU, 32'd100, 32'd0, rh, rl, rdz);
        check("ref_dz", 64'(rdz), 64'd1);

        // MULTU all ones squared.
        launch(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        wait_done(lat, scnt);
        check("multu_lat", 64'(lat), 64'(MUL_LAT));
        check("multu_hi", 64'(hi_o), 64'hFFFF_FFFE);
        check("multu_lo", 64'(lo_o), 64'h0000_0001);

        // MULT -3 x 7 with stall profile.
        launch(OP_MULT, 32'hFFFF_FFFD, 32'd7);
        wait_done(lat, scnt);
        check("mult_stall_cycles", 64'(scnt), 64'(MUL_LAT - 1));
        check("mult_hi", 64'(hi_o), 64'hFFFF_FFFF);
        check("mult_lo", 64'(lo_o), 64'hFFFF_FFEB);

        // Signed divisions.
        launch(OP_DIV, 32'hFFFF_FFF9, 32'd2);
        wait_done(lat, scnt);
        check("div_lat", 64'(lat), 64'(DIV_LAT));
        check("div_lo", 64'(lo_o), 64'hFFFF_FFFD);
        check("div_hi", 64'(hi_o), 64'hFFFF_FFFF);
        launch(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
        wait_done(lat, scnt);
        check("div_wrap_lo", 64'(lo_o), 64'h8000_0000);
        check("div_wrap_hi", 64'(hi_o), 64'd0);
        check("div_wrap_dz", 64'(div_by_zero_o), 64'd0);

        // Divide by zero.
        launch(OP_DIVU, 32'd100, 32'd0);
        wait_done(lat, scnt);
        check("dz_lat", 64'(lat), 64'd1);
        check("dz_lo", 64'(lo_o), 64'hFFFF_FFFF);
        check("dz_hi", 64'(hi_o), 64'h0000_0064);
        check("dz_flag", 64'(div_by_zero_o), 64'd1);

        // DIVU 9/4 annulled in cycle 10.
        launch(OP_DIVU, 32'd9, 32'd4);
        @(negedge clk);
        check("dz_cleared", 64'(div_by_zero_o), 64'd0);
        repeat (9) @(posedge clk);
        #1;
        annul_i = 1'b1;
        @(posedge clk);
        #1;
        annul_i = 1'b0;
        @(negedge clk);
        check("annul_busy", 64'(busy_o), 64'd0);
        check("annul_hi", 64'(hi_o), 64'h0000_0064);
        check("annul_lo", 64'(lo_o), 64'hFFFF_FFFF);
        ndone = 0;
        repeat (40) begin
            @(negedge clk);
            if (done_o) ndone++;
        end
        check("annul_no_done", 64'(ndone), 64'd0);
        @(posedge clk);
        #1;

        // Same, reset in cycle 10.
        launch(OP_DIVU, 32'd9, 32'd4);
        repeat (9) @(posedge clk);
        #1;
        rst = 1'b1;
        @(negedge clk);
        check("midrst_hi", 64'(hi_o), 64'd0);
        check("midrst_lo", 64'(lo_o), 64'd0);
        check("midrst_busy", 64'(busy_o), 64'd0);
        check("midrst_stall", 64'(stallreq_o), 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // First start after reset.
        launch(OP_DIVU, 32'd9, 32'd4);
        wait_done(lat, scnt);
        check("post_rst_lat", 64'(lat), 64'(DIV_LAT));
        check("post_rst_lo", 64'(lo_o), 64'd2);
        check("post_rst_hi", 64'(hi_o), 64'd1);

        // start_i held across a whole DIVU; operands change mid-flight.
        op_i = OP_DIVU;
        src_a_i = 32'd1000;
        src_b_i = 32'd7;
        start_i = 1'b1;
        ndone = 0;
        done_at = -1;
        for (int k = 0; k <= DIV_LAT; k++) begin
            @(negedge clk);
            if (done_o) begin
                ndone++;
                done_at = k;
            end
            @(posedge clk);
            #1;
            if (k == 5) begin
                src_a_i = 32'd5;
                src_b_i = 32'd1;
            end
        end
        start_i = 1'b0;
        check("held_done_count", 64'(ndone), 64'd1);
        check("held_done_cycle", 64'(done_at), 64'(DIV_LAT));
        check("held_lo", 64'(lo_o), 64'd142);
        check("held_hi", 64'(hi_o), 64'd6);
        ndone = 0;
        repeat (40) begin
            @(negedge clk);
            if (done_o) ndone++;
        end
        check("held_no_relaunch", 64'(ndone), 64'd0);
        @(posedge clk);
        #1;

        // Randomized traffic checked by the compare process.
        for (int i = 0; i < 4000; i++) begin
            start_i = ($urandom % 3) == 0;
            annul_i = ($urandom % 40) == 0;
            rst     = ($urandom % 700) == 0;
            op_i    = 2'($urandom);
            src_a_i = pick();
            src_b_i = pick();
            @(posedge clk);
            #1;
        end
        rst = 1'b0;
        start_i = 1'b0;
        annul_i = 1'b0;
        repeat (40) @(posedge clk);
        #1;

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
